// File: rtl/mux_pkg.sv
// Shared constants for the mux primitives: default data width and select encoding.
package mux_pkg;

  localparam int unsigned MUX_DATA_W_DEFAULT = 2;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/mux_2to1.sv
// Two-input word selector driving one registered bit of the chosen word.
// The output flop clears asynchronously on rst and reloads on every rising clk edge.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W  = MUX_DATA_W_DEFAULT,
  parameter int unsigned OUT_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D0,
  input  logic [DATA_W-1:0] D1,
  input  logic              sel,
  output logic              mux_out
);

  if (DATA_W < 1) begin : gen_bad_width
    $error("mux_2to1: DATA_W must be at least 1");
  end
  if (OUT_BIT >= DATA_W) begin : gen_bad_out_bit
    $error("mux_2to1: OUT_BIT must be less than DATA_W");
  end

  logic [DATA_W-1:0] word;
  logic              mux_out_d;
  logic              mux_out_q;
  // Only bit OUT_BIT matters; the rest of the word is deliberately dropped.
  logic              unused_word;

  always_comb begin
    word        = (sel == SEL_D1) ? D1 : D0;
    mux_out_d   = word[OUT_BIT];
    unused_word = ^word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_out_q <= 1'b0;
    end else begin
      mux_out_q <= mux_out_d;
    end
  end

  assign mux_out = mux_out_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed-vector bench for mux_2to1: reset, select, bit masking, mid-cycle and async reset.
module tb_mux_2to1;

  logic       clk;
  logic       rst;
  logic [1:0] D0;
  logic [1:0] D1;
  logic       sel;
  logic       mux_out;

  int unsigned n_tests;
  int unsigned n_failed;

  mux_2to1 #(
    .DATA_W  (2),
    .OUT_BIT (0)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .D0      (D0),
    .D1      (D1),
    .sel     (sel),
    .mux_out (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] d0, input logic [1:0] d1, input logic s,
                      input logic exp, input string tag);
    D0  = d0;
    D1  = d1;
    sel = s;
    tick();
    check(tag, mux_out, exp);
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst = 1'b0;
    D0  = 2'b00;
    D1  = 2'b00;
    sel = 1'b0;

    // Reset with inputs that would otherwise load a 1.
    #2;
    D0  = 2'b11;
    D1  = 2'b11;
    sel = 1'b1;
    rst = 1'b1;
    #1;
    check("reset_immediate", mux_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", mux_out, 1'b0);
    end

    // First edge after release loads the selected bit.
    rst = 1'b0;
    D0  = 2'b00;
    D1  = 2'b01;
    sel = 1'b0;
    tick();
    check("sel_d0_zero", mux_out, 1'b0);
    load(2'b01, 2'b00, 1'b0, 1'b1, "sel_d0_one");

    load(2'b00, 2'b01, 1'b1, 1'b1, "sel_d1_one");
    load(2'b01, 2'b00, 1'b1, 1'b0, "sel_d1_zero");

    load(2'b10, 2'b11, 1'b0, 1'b0, "mask_d0_bit1");
    load(2'b10, 2'b11, 1'b1, 1'b1, "mask_d1_bit0");
    load(2'b11, 2'b10, 1'b1, 1'b0, "mask_d1_bit1");

    // sel and data change together: new pair is used.
    load(2'b10, 2'b01, 1'b0, 1'b0, "joint_change_a");
    load(2'b11, 2'b00, 1'b0, 1'b1, "joint_change_b");

    // Mid-cycle toggling must not reach the output before the next edge.
    #2;
    sel = 1'b1;
    D1  = 2'b00;
    #1;
    check("mid_cycle_hold_a", mux_out, 1'b1);
    D0  = 2'b00;
    sel = 1'b0;
    #1;
    check("mid_cycle_hold_b", mux_out, 1'b1);
    sel = 1'b1;
    D1  = 2'b10;
    #1;
    check("mid_cycle_hold_c", mux_out, 1'b1);
    tick();
    check("mid_cycle_final", mux_out, 1'b0);

    // Async reset between edges, then recovery.
    load(2'b00, 2'b01, 1'b1, 1'b1, "pre_reset_one");
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", mux_out, 1'b0);
    tick();
    check("async_reset_edge", mux_out, 1'b0);
    rst = 1'b0;
    sel = 1'b1;
    D1  = 2'b01;
    tick();
    check("post_reset_load", mux_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Two-input selector with a registered 1-bit output. It picks between data words `D0` and `D1` under control of `sel` and drives bit 0 of the chosen word on `mux_out`. It is a leaf datapath primitive in the bootcamp block set, placed wherever a clocked, reset-clean single-bit select is needed.

## Interface

Parameters:
- `DATA_W`, default 2: width of `D0` and `D1`. Minimum 1.
- `OUT_BIT`, default 0: index of the selected word driven onto `mux_out`. Must satisfy 0 ≤ `OUT_BIT` < `DATA_W`.

Ports:
- `clk`: input, 1 bit. Single clock. All state updates on the rising edge.
- `rst`: input, 1 bit. Reset, asynchronous and active-high. `mux_out` clears immediately; release is synchronised to `clk` by the integrator.
- `D0`: input, `DATA_W` bits. Data word routed when `sel` = 0.
- `D1`: input, `DATA_W` bits. Data word routed when `sel` = 1.
- `sel`: input, 1 bit. Select. 0 picks `D0`, 1 picks `D1`.
- `mux_out`: output, 1 bit. Registered bit `OUT_BIT` of the selected word.

## Operation

- Combinational select: `word = sel ? D1 : D0`.
- Next state: `mux_out_next = word[OUT_BIT]`. All other bits of the word are ignored.
- X/Z on `sel` is not resolved by the block. Verification treats X on `sel` outside reset as a stimulus error.
- No enable, no handshake. The register loads on every rising `clk` edge while `rst` = 0.
- No state machine. The only state is the single `mux_out` flop.

## Timing

- Reset value: `mux_out` = 0.
- Assertion of `rst` clears `mux_out` asynchronously, independent of `clk`.
- While `rst` is high, `mux_out` holds 0 regardless of `D0`, `D1` and `sel`.
- Latency is one cycle. Inputs sampled at edge N appear on `mux_out` after edge N and hold until edge N+1.
- First load after reset release: the first rising edge with `rst` low loads the selected bit.
- Inputs changing between edges have no effect on `mux_out` until the next edge. The output never glitches mid-cycle.
- If `sel` and the data inputs change in the same cycle, the new `sel` and the new data are used together at the next edge.
- If `rst` asserts in the same cycle as a load, reset wins and `mux_out` = 0.
- Setup and hold relative to `clk` apply to `D0`, `D1` and `sel`.

## Structure

- Shared package `mux_pkg` holds:
  - the constant `MUX_DATA_W_DEFAULT` = 2;
  - the select encoding constants `SEL_D0` = 1'b0 and `SEL_D1` = 1'b1.
- Elaboration-time check: error if `OUT_BIT` ≥ `DATA_W`.
- Single module, no sub-modules. The select and the flop are too small to split.
- Integration note: the block is intended to be instantiated many times in datapaths. Keep it parameter-driven with no internal constants beyond the package.

## Test plan

- Reset: assert `rst` with `D0`=2'b11, `D1`=2'b11, `sel`=1 → `mux_out`=0 immediately and on every edge while `rst`=1.
- Select D0: `D0`=2'b00, `D1`=2'b01, `sel`=0, one edge → `mux_out`=0. Then `D0`=2'b01, `D1`=2'b00, `sel`=0, one edge → `mux_out`=1.
- Select D1: `D0`=2'b00, `D1`=2'b01, `sel`=1, one edge → `mux_out`=1. Then `D0`=2'b01, `D1`=2'b00, `sel`=1, one edge → `mux_out`=0.
- Bit masking: `D0`=2'b10, `sel`=0 → `mux_out`=0, because only bit 0 is used. `D1`=2'b11, `sel`=1 → `mux_out`=1.
- Mid-cycle change: toggle `sel` and the data between edges → `mux_out` unchanged until the next rising edge, then reflects the final values.
- Reset mid-operation: `mux_out`=1, then assert `rst` between edges → 0 at once. Release `rst` with `sel`=1, `D1`=2'b01 → `mux_out`=1 after the first edge.
